// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick_sched timer scheduler.
package tick_sched_pkg;

  localparam int TICK_CLK_DIV_10MS = 1_000_000;
  // Widest period the channel record can hold; the top-level PW must not exceed it.
  localparam int PW_MAX = 16;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  typedef struct packed {
    logic [PW_MAX-1:0] rem;
    logic [PW_MAX-1:0] per;
    logic              periodic;
    logic              active;
    logic              pending;
    logic              overrun;
  } chan_t;

endpackage

// File: rtl/tick_sched_prescaler.sv
// Divides clk into a registered one-cycle base tick; enable low freezes the count.
module tick_prescaler
  import tick_sched_pkg::*;
#(
  parameter int CLK_DIV = TICK_CLK_DIV_10MS
) (
  input  logic clk,
  input  logic resetSW_n,
  input  logic enable,
  output logic tick
);

  localparam int PCW = $clog2(CLK_DIV);

  logic [PCW-1:0] pcnt;
  logic           wrap;

  assign wrap = (pcnt == PCW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge resetSW_n) begin
    if (!resetSW_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= enable && wrap;
      if (enable) begin
        pcnt <= wrap ? '0 : pcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_sched.sv
// Multi-channel countdown timers on a shared base tick, expiries serialized round-robin.
// Optional overrun detection is compiled in with TICK_SCHED_OVERRUN_EN.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int CLK_DIV = TICK_CLK_DIV_10MS,
  parameter int NCH     = 4,
  parameter int PW      = 16
) (
  input  logic                    clk,
  input  logic                    resetSW_n,
  input  logic                    enable,
  input  logic                    cfg_valid,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic [PW-1:0]           cfg_period,
  input  logic                    cfg_periodic,
  input  logic                    cfg_stop,
  output logic                    tick,
  output logic                    evt_valid,
  output logic [$clog2(NCH)-1:0]  evt_ch,
  input  logic                    evt_ready,
  output logic [NCH-1:0]          active,
  output logic [NCH-1:0]          overrun,
  output state_t                  dbg_state
);

  localparam int CW = $clog2(NCH);

  chan_t          ch [NCH];
  state_t         state;
  logic [CW-1:0]  rr_ptr;
  logic           found;
  logic [CW-1:0]  pick;
  logic [CW-1:0]  idx;
  logic [NCH-1:0] cap;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk       (clk),
    .resetSW_n (resetSW_n),
    .enable    (enable),
    .tick      (tick)
  );

  // First pending channel at or after rr_ptr, searched cyclically.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = CW'((int'(rr_ptr) + i) % NCH);
      if (!found && ch[idx].pending) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    cap = '0;
    if (state == ST_IDLE && found) cap[pick] = 1'b1;
  end

  // A config write beats a same-cycle tick; a capture clears pending before
  // a same-cycle expiry re-sets it, so that case is not an overrun.
  always_ff @(posedge clk or negedge resetSW_n) begin
    if (!resetSW_n) begin
      for (int i = 0; i < NCH; i++) ch[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_valid && cfg_ch == CW'(i)) begin
          ch[i].pending <= 1'b0;
          ch[i].overrun <= 1'b0;
          if (cfg_stop || cfg_period == '0) begin
            ch[i].active <= 1'b0;
          end else begin
            ch[i].rem      <= PW_MAX'(cfg_period);
            ch[i].per      <= PW_MAX'(cfg_period);
            ch[i].periodic <= cfg_periodic;
            ch[i].active   <= 1'b1;
          end
        end else if (tick && ch[i].active) begin
          if (ch[i].rem == PW_MAX'(1)) begin
            ch[i].pending <= 1'b1;
`ifdef TICK_SCHED_OVERRUN_EN
            if (ch[i].pending && !cap[i]) ch[i].overrun <= 1'b1;
`endif
            if (ch[i].periodic) ch[i].rem <= ch[i].per;
            else                ch[i].active <= 1'b0;
          end else begin
            ch[i].rem <= ch[i].rem - 1'b1;
            if (cap[i]) ch[i].pending <= 1'b0;
          end
        end else if (cap[i]) begin
          ch[i].pending <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    active  = '0;
    overrun = '0;
    for (int i = 0; i < NCH; i++) begin
      active[i]  = ch[i].active;
      overrun[i] = ch[i].overrun;
    end
  end

  // Event port: an event transfers on a rising edge where evt_valid and
  // evt_ready are both high; evt_ch is stable while evt_valid is high, and
  // evt_valid never drops without that transfer (except on reset).
  always_ff @(posedge clk or negedge resetSW_n) begin
    if (!resetSW_n) begin
      state     <= ST_IDLE;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            evt_ch    <= pick;
            evt_valid <= 1'b1;
            state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            rr_ptr    <= (evt_ch == CW'(NCH - 1)) ? '0 : evt_ch + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched: directed test-plan scenarios plus randomized traffic,
// all checked against a per-cycle behavioural model and an event scoreboard.
module tb_tick_sched;
  import tick_sched_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int NCH     = 4;
  localparam int PW      = 16;

  logic           clk = 1'b0;
  logic           resetSW_n;
  logic           enable;
  logic           cfg_valid;
  logic [1:0]     cfg_ch;
  logic [PW-1:0]  cfg_period;
  logic           cfg_periodic;
  logic           cfg_stop;
  logic           tick;
  logic           evt_valid;
  logic [1:0]     evt_ch;
  logic           evt_ready;
  logic [NCH-1:0] active;
  logic [NCH-1:0] overrun;
  state_t         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

`ifdef TICK_SCHED_OVERRUN_EN
  bit ovr_en = 1'b1;
`else
  bit ovr_en = 1'b0;
`endif

  // reference model state
  int         m_en_cnt;
  bit         m_tick;
  int         m_rem [NCH];
  int         m_per [NCH];
  bit         m_periodic [NCH];
  bit         m_act [NCH];
  bit         m_pend [NCH];
  bit         m_ovr [NCH];
  bit         m_busy;
  int         m_cur;
  int         m_rr;
  logic [1:0] exp_q [$];
  int         acc_log [$];

  tick_sched #(.CLK_DIV(CLK_DIV), .NCH(NCH), .PW(PW)) dut (
    .clk          (clk),
    .resetSW_n    (resetSW_n),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ch       (cfg_ch),
    .cfg_period   (cfg_period),
    .cfg_periodic (cfg_periodic),
    .cfg_stop     (cfg_stop),
    .tick         (tick),
    .evt_valid    (evt_valid),
    .evt_ch       (evt_ch),
    .evt_ready    (evt_ready),
    .active       (active),
    .overrun      (overrun),
    .dbg_state    (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en_cnt = 0;
    m_tick   = 1'b0;
    m_busy   = 1'b0;
    m_cur    = 0;
    m_rr     = 0;
    for (int i = 0; i < NCH; i++) begin
      m_rem[i] = 0; m_per[i] = 0; m_periodic[i] = 0;
      m_act[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
    end
    exp_q.delete();
  endtask

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_step();
    int cap;
    bit nt;
    bit p;
    cap = -1;
    nt  = enable && (m_en_cnt == CLK_DIV - 1);
    if (enable) m_en_cnt = (m_en_cnt + 1) % CLK_DIV;
    if (!m_busy) begin
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_rr + k) % NCH;
        if (cap < 0 && m_pend[c]) cap = c;
      end
    end
    if (m_busy && evt_ready) begin
      m_busy = 1'b0;
      m_rr   = (m_cur + 1) % NCH;
    end else if (!m_busy && cap >= 0) begin
      m_busy = 1'b1;
      m_cur  = cap;
      exp_q.push_back(2'(cap));
    end
    for (int i = 0; i < NCH; i++) begin
      p = m_pend[i] && (cap != i);
      if (cfg_valid && int'(cfg_ch) == i) begin
        m_pend[i] = 1'b0;
        m_ovr[i]  = 1'b0;
        if (cfg_stop || cfg_period == 0) begin
          m_act[i] = 1'b0;
        end else begin
          m_rem[i]      = int'(cfg_period);
          m_per[i]      = int'(cfg_period);
          m_periodic[i] = cfg_periodic;
          m_act[i]      = 1'b1;
        end
      end else if (m_tick && m_act[i]) begin
        if (m_rem[i] == 1) begin
          if (ovr_en && p) m_ovr[i] = 1'b1;
          m_pend[i] = 1'b1;
          if (m_periodic[i]) m_rem[i] = m_per[i];
          else               m_act[i] = 1'b0;
        end else begin
          m_rem[i]  = m_rem[i] - 1;
          m_pend[i] = p;
        end
      end else begin
        m_pend[i] = p;
      end
    end
    m_tick = nt;
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] ea, eo;
    for (int i = 0; i < NCH; i++) begin
      ea[i] = m_act[i];
      eo[i] = m_ovr[i];
    end
    check("tick", tick, m_tick);
    check("evt_valid", evt_valid, m_busy);
    check("dbg_state", dbg_state == ST_PRESENT, m_busy);
    if (m_busy) check("evt_ch", evt_ch, m_cur);
    check("active", active, ea);
    check("overrun", overrun, eo);
  endtask

  // driver: one clock cycle with the given inputs
  task automatic step(input bit en, input bit cv, input int ch, input int per,
                      input bit peri, input bit stop, input bit rdy);
    enable       = en;
    cfg_valid    = cv;
    cfg_ch       = 2'(ch);
    cfg_period   = PW'(per);
    cfg_periodic = peri;
    cfg_stop     = stop;
    evt_ready    = rdy;
    if (evt_valid && evt_ready) begin
      acc_log.push_back(int'(evt_ch));
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else                   check("sb_evt", evt_ch, exp_q.pop_front());
    end
    model_step();
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    resetSW_n = 1'b0;
    enable = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0;
    cfg_periodic = 1'b0; cfg_stop = 1'b0; evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    acc_log.delete();
    cyc = 0;
    check("rst_tick", tick, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_ch", evt_ch, 0);
    check("rst_active", active, 0);
    check("rst_overrun", overrun, 0);
    resetSW_n = 1'b1;
  endtask

  initial begin
    int t3, tv, nt, nev;
    bit pv;
    int evq [$];

    // prescaler cadence and enable gating
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      idle(1, 1'b1);
      check("tick_seq", tick, (k % 4) == 0);
    end
    for (int k = 13; k <= 23; k++) begin
      step(k > 15, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      check("tick_gate", tick, (k == 19) || (k == 23));
    end

    // ch0 one-shot, period 3
    step(1'b1, 1'b1, 0, 3, 1'b0, 1'b0, 1'b1);
    t3 = -100; tv = -1; nt = 0;
    for (int k = 0; k < 30; k++) begin
      idle(1, 1'b1);
      if (tick) begin
        nt++;
        if (nt == 3) t3 = cyc;
      end
      if (evt_valid && tv < 0) tv = cyc;
    end
    check("oneshot_lat", tv - t3, 2);
    check("oneshot_ch0_idle", active[0], 0);
    nev = 0;
    for (int k = 0; k < 20; k++) begin
      idle(1, 1'b1);
      if (evt_valid) nev++;
    end
    check("oneshot_no_more", nev, 0);

    // ch1 periodic, period 2, then stopped
    step(1'b1, 1'b1, 1, 2, 1'b1, 1'b0, 1'b1);
    pv = 1'b0;
    for (int k = 0; k < 40; k++) begin
      idle(1, 1'b1);
      if (evt_valid && !pv) evq.push_back(cyc);
      pv = evt_valid;
    end
    check("periodic_count", evq.size() >= 3, 1);
    if (evq.size() >= 3) begin
      check("periodic_gap0", evq[1] - evq[0], 8);
      check("periodic_gap1", evq[2] - evq[1], 8);
    end
    step(1'b1, 1'b1, 1, 5, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b1);
    nev = 0;
    for (int k = 0; k < 20; k++) begin
      idle(1, 1'b1);
      if (evt_valid) nev++;
    end
    check("stop_no_events", nev, 0);
    check("stop_inactive", active[1], 0);

    // ch0, ch2, ch3 expiring on the same tick
    do_reset();
    step(1'b1, 1'b1, 0, 2, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 2, 2, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3, 2, 1'b1, 1'b0, 1'b1);
    idle(23, 1'b1);
    check("rr_count", acc_log.size() >= 6, 1);
    if (acc_log.size() >= 6) begin
      check("rr_0", acc_log[0], 0);
      check("rr_1", acc_log[1], 2);
      check("rr_2", acc_log[2], 3);
      check("rr_3", acc_log[3], 0);
      check("rr_4", acc_log[4], 2);
      check("rr_5", acc_log[5], 3);
    end

    // ch0 period 1 with a stalled consumer: re-pend then overrun
    do_reset();
    step(1'b1, 1'b1, 0, 1, 1'b1, 1'b0, 1'b0);
    idle(13, 1'b0);
    check("stall_valid", evt_valid, 1);
    check("stall_ch", evt_ch, 0);
    check("ovr_sticky", overrun[0], ovr_en);
    step(1'b1, 1'b1, 0, 1, 1'b1, 1'b0, 1'b0);
    check("ovr_cleared", overrun[0], 0);
    idle(6, 1'b1);

    // config write on the tick where ch2 would expire; then reset mid-present
    do_reset();
    step(1'b1, 1'b1, 2, 2, 1'b0, 1'b0, 1'b0);
    idle(7, 1'b0);
    check("collide_tick_hi", tick, 1);
    step(1'b1, 1'b1, 2, 5, 1'b0, 1'b0, 1'b0);
    tv = -1;
    for (int k = 0; k < 26; k++) begin
      idle(1, 1'b0);
      if (evt_valid && tv < 0) tv = cyc;
    end
    check("collide_first_evt", tv, 30);
    check("collide_present", evt_valid, 1);
    #2;
    resetSW_n = 1'b0;
    #1;
    check("async_rst_valid", evt_valid, 0);
    check("async_rst_active", active, 0);
    check("async_rst_tick", tick, 0);

    // randomized traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset();
      step($urandom_range(0, 9) != 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, NCH - 1),
           $urandom_range(0, 6),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_sched.md
# tick_sched

Multi-channel software-timer scheduler on a shared 10 ms base tick. An internal prescaler divides the 100 MHz `clk` into a one-cycle base tick. NCH countdown channels consume that tick, one-shot or periodic, and their expiries are serialized onto a single valid/ready event port by a round-robin arbiter. It sits between the board clock and the control logic that needs several independent coarse timeouts.

## Interface
- `CLK_DIV`, 1_000_000: clk cycles per base tick (10 ms at 100 MHz); must be ≥ 2.
- `NCH`, 4: number of timer channels, 2..16.
- `PW`, 16: period width in base ticks.
- `clk` in 1: 100 MHz system clock; all logic on its rising edge.
- `resetSW_n` in 1: reset, asynchronous assert, active-low.
- `enable` in 1: prescaler runs when high; low freezes the prescaler count (no clear).
- `cfg_valid` in 1: one-cycle configuration write strobe.
- `cfg_ch` in $clog2(NCH): target channel.
- `cfg_period` in PW: period in ticks.
- `cfg_periodic` in 1: 1 = auto-reload, 0 = one-shot.
- `cfg_stop` in 1: 1 = stop channel; period and mode ignored.
- `tick` out 1: one-cycle base-tick pulse.
- `evt_valid` out 1: expiry event presented.
- `evt_ch` out $clog2(NCH): expired channel index.
- `evt_ready` in 1: consumer accepts the event.
- `active` out NCH: channel running.
- `overrun` out NCH: sticky; expiry lost because the previous one was still pending.

## Operation
- Prescaler `pcnt` counts 0..CLK_DIV-1 while `enable` is high. `tick`=1 in the cycle `pcnt`==CLK_DIV-1 and `enable`=1; `pcnt` then wraps to 0.
- Per channel: `rem` (PW), `per` (PW), `periodic`, `active`, `pending`, `overrun`.
- Config write with `cfg_stop`=0 and `cfg_period`≠0: `rem`=`per`=`cfg_period`, `periodic` loaded, `active`=1, `pending`=0, `overrun`=0.
- Config write with `cfg_stop`=1 or `cfg_period`=0: `active`=0, `pending`=0, `overrun`=0.
- On `tick`, for each active channel not written in the same cycle:
  - If `rem`==1, the channel expires. It sets `pending`, and also sets `overrun` if `pending` was already 1. It reloads `rem`=`per` if periodic; otherwise it clears `active`.
  - Otherwise `rem` decrements.
- Config write and tick on the same channel in the same cycle: the config wins and the tick is ignored for that channel. Other channels are unaffected.
- Event FSM, states IDLE and PRESENT:
  - IDLE: if any `pending` bit is set, pick the first set bit at or after `rr_ptr` (cyclic). Load `evt_ch`, clear that `pending` bit, go to PRESENT.
  - PRESENT: hold `evt_valid`=1 with `evt_ch` stable. On `evt_ready`, set `rr_ptr`=`evt_ch`+1 (mod NCH) and return to IDLE.
- A channel may expire again while its event is being PRESENTed. This sets `pending` again, without overrun, because the bit was already cleared at capture.
- A stop or reconfigure of a channel whose event is being PRESENTed does not withdraw that event.
- Reset values: `pcnt`=0, `tick`=0, all channel state 0, `active`=0, `overrun`=0, FSM=IDLE, `evt_valid`=0, `evt_ch`=0, `rr_ptr`=0.
- Reset asserted mid-operation returns every register to its reset value immediately, with no event drained.

## Timing
- First `tick` occurs CLK_DIV cycles after `resetSW_n` deasserts, with `enable` held high.
- Expiry latency: `tick` high in cycle T; `pending` high in T+1; `evt_valid` high in T+2 if the FSM is IDLE.
- Event throughput: one event per 2 cycles maximum (PRESENT→IDLE→PRESENT).
- A period of P ticks set by a write in cycle W expires on the P-th `tick` after W. Phase jitter is up to one tick, because the prescaler is not realigned by the write.
- All outputs are registered except `active` and `overrun`, which are direct register bits.

## Configuration
- `TICK_SCHED_OVERRUN_EN` defined: overrun detection logic and sticky bits are present.
- Not defined: the `overrun` port is still present but tied to 0. The expiry-while-pending case silently merges into the single pending event.

## Structure
- Package `tick_sched_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_PRESENT`).
  - Default constant `TICK_CLK_DIV_10MS`=1_000_000.
  - Channel record typedef (`rem`, `per`, `periodic`, `active`, `pending`, `overrun`).
- Sub-module `tick_prescaler` contains `pcnt`, `enable` and the `tick` pulse. The top level contains the channel array and the event FSM/arbiter.

## Test plan
All scenarios run with CLK_DIV=4, NCH=4.
- Reset then `enable`=1: `tick` pulses on cycles 4, 8, 12; `enable` low for 3 cycles delays the next pulse by exactly 3.
- ch0 one-shot with period 3, `evt_ready`=1:
  - `evt_valid` with `evt_ch`=0 appears 2 cycles after the 3rd tick.
  - `active[0]`=0 afterwards; no further events.
- ch1 periodic with period 2: events every 8 cycles. `cfg_stop` to ch1 then yields no events, and `active[1]`=0.
- ch0, ch2 and ch3 expire on the same tick, with `evt_ready` always 1: events are presented in order 0, 2, 3; the next simultaneous round starts after 3 (order 0, 2, 3 again).
- ch0 periodic with period 1, `evt_ready`=0:
  - `evt_ch`=0 is held stable.
  - The second expiry sets `pending`; the third sets `overrun[0]`=1 with the macro defined, 0 without.
  - A cfg write to ch0 clears `overrun[0]`.
- Config write to ch2 in the same cycle as `tick`, with `rem`==1: no expiry occurs and `rem` reloads to the new period. Asserting `resetSW_n`=0 mid-PRESENT drops `evt_valid` immediately.
